// File: rtl/mealy_1001_detector.sv
// Serial 1-0-0-1 pattern detector (Mealy FSM), one bit per clk; macro MEALY_1001_OVERLAP_EN enables overlapping matches.
// Latency: dout is combinational from state and din, asserted in the same cycle as the final '1'.
// Backpressure: none; a bit is consumed on every rising clk edge and dout is a one-cycle strobe.
module mealy_1001_detector (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam logic [1:0] IDLE = 2'd0;  // no progress
  localparam logic [1:0] S1   = 2'd1;  // seen "1"
  localparam logic [1:0] S10  = 2'd2;  // seen "10"
  localparam logic [1:0] S100 = 2'd3;  // seen "100"

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       match;

  // Next-state and raw match decode; the terminating '1' either restarts
  // from scratch or seeds the next pattern, depending on the overlap build.
  always_comb begin
    state_nxt = IDLE;
    match     = 1'b0;
    case (state)
      IDLE: state_nxt = din ? S1 : IDLE;
      S1:   state_nxt = din ? S1 : S10;
      S10:  state_nxt = din ? S1 : S100;
      S100: begin
        if (din) begin
          match = 1'b1;
`ifdef MEALY_1001_OVERLAP_EN
          state_nxt = S1;
`else
          state_nxt = IDLE;
`endif
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        match     = 1'b0;
      end
    endcase
  end

  // State register; a low reset at the edge discards any partial pattern.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Output is gated by reset so it reads 0 even before the first reset edge.
  assign dout = match & reset;

endmodule

// File: tb/tb_mealy_1001_detector.sv
// Bench for mealy_1001_detector: directed vectors with literal expectations plus
// a sliding-window reference model compared against dout on every cycle.
// Build with +define+MEALY_1001_OVERLAP_EN to exercise the overlapping variant.
module tb_mealy_1001_detector;

  logic clk;
  logic reset;
  logic din;
  logic dout;

  int total = 0;
  int bad   = 0;

`ifdef MEALY_1001_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif

  mealy_1001_detector dut (
    .clk   (clk),
    .reset (reset),
    .din   (din),
    .dout  (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the bits accepted since the last reset/restart; a match
  // is the last three held bits followed by the present din reading 1001.
  logic [2:0] hist    = 3'b000;
  int         cnt     = 0;
  bit         started = 1'b0;

  function automatic bit model_exp();
    return reset && started && (cnt >= 3) && ({hist, din} == 4'b1001);
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      cnt     = 0;
      hist    = 3'b000;
      started = 1'b1;
    end else if (started) begin
      if (model_exp()) begin
        if (OVL) begin
          hist = 3'b001;
          cnt  = 1;
        end else begin
          hist = 3'b000;
          cnt  = 0;
        end
      end else begin
        hist = {hist[1:0], din};
        if (cnt < 3) cnt = cnt + 1;
      end
    end
  end

  // Every-cycle comparison against the model once a reset edge has defined the state.
  always @(negedge clk) begin
    if (started || !reset) begin
      total = total + 1;
      if (dout !== model_exp()) begin
        bad = bad + 1;
        $display("FAIL model_cmp t=%0t dout=%0b expected=%0b", $time, dout, model_exp());
      end
    end
  end

  task automatic check(input string name, input logic got, input logic want);
    total = total + 1;
    if (got !== want) begin
      bad = bad + 1;
      $display("FAIL %s t=%0t got=%0b want=%0b", name, $time, got, want);
    end
  endtask

  // Drive one bit just after an edge, then check DUT and model mid-cycle.
  task automatic step(input string name, input logic d, input logic want);
    din = d;
    @(negedge clk);
    #1;
    check(name, dout, want);
    check({name, "_model"}, model_exp(), want);
    @(posedge clk);
    #1;
  endtask

  // Apply a bit sequence; exp[i] is the required dout for bits[i] (MSB-first).
  task automatic seq(input string name, input int n, input logic [31:0] bits, input logic [31:0] exp);
    for (int i = n - 1; i >= 0; i--) begin
      step(name, bits[i], exp[i]);
    end
  endtask

  task automatic do_reset(input int edges);
    reset = 1'b0;
    din   = 1'b1;
    repeat (edges) begin
      @(negedge clk);
      #1;
      check("reset_dout", dout, 1'b0);
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    din   = 1'b0;
  endtask

  logic [31:0] stream;

  initial begin
    reset = 1'b0;
    din   = 1'b1;
    #1;
    check("pre_edge_reset_low", dout, 1'b0);
    @(posedge clk);
    #1;

    // Reset held two edges with din=1, then a clean 1001.
    do_reset(2);
    seq("basic", 5, 32'b10010, 32'b00010);

    do_reset(1);
    if (OVL) seq("overlap", 7, 32'b1001001, 32'b0001001);
    else     seq("overlap", 7, 32'b1001001, 32'b0001000);

    do_reset(1);
    seq("near_miss", 9, 32'b111001010, 32'b000001000);
    do_reset(1);
    seq("no_1000_1", 5, 32'b10001, 32'b00000);
    seq("after_1000", 4, 32'b0001, 32'b0000);

    // Reset in the middle of a pattern wipes progress.
    do_reset(1);
    seq("mid_pre", 3, 32'b100, 32'b000);
    reset = 1'b0;
    din   = 1'b1;
    @(negedge clk);
    #1;
    check("mid_reset_dout", dout, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    seq("mid_post", 4, 32'b1001, 32'b0001);

    // Mealy timing: in S100, din rises mid-cycle and dout follows at once.
    do_reset(1);
    seq("mealy_pre", 3, 32'b100, 32'b000);
    din = 1'b0;
    #1;
    check("mealy_din0", dout, 1'b0);
    din = 1'b1;
    #1;
    check("mealy_din1", dout, 1'b1);
    @(posedge clk);
    #1;
    if (OVL) seq("mealy_next", 3, 32'b001, 32'b001);
    else     seq("mealy_next", 3, 32'b001, 32'b000);

    // Longer fixed stream judged by the model alone.
    do_reset(1);
    stream = 32'b1001_0011_0010_0110_0100_1100_1001_1001;
    for (int i = 31; i >= 0; i--) begin
      din = stream[i];
      @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
